// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser, debouncer, polarity normaliser
// and press/release strobe generator, plus a stretched, synchronously
// released system reset.
// Optional feature macro: KEY_COND_REPEAT_EN (auto-repeat on held inputs).
// The release strobe port is named release_o because "release" is a
// reserved word in SystemVerilog.
module key_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int POR_HOLD        = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_o,
  output logic                rst_out_n
);

  // Raw idle level; also the XOR term that makes 1 mean pressed.
  localparam logic POL = (ACTIVE_LOW != 0);

  localparam int            DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam int            HW   = (POR_HOLD > 1) ? $clog2(POR_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(POR_HOLD - 1);

  if (CHANNELS < 1 || CHANNELS > 32 || DEBOUNCE_CYCLES < 1 || POR_HOLD < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_conditioner: parameter out of range");
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic          r_sync1, r_sync2;
    logic          r_level, r_press, r_rel;
    logic [DW-1:0] r_dcnt;
    logic          w_s, w_tog, w_rep;

    assign w_s   = r_sync2 ^ POL;
    // Level flips on this edge: input has differed for the full window.
    assign w_tog = (w_s != r_level) && (r_dcnt == DMAX);

    // Two-flop synchroniser, parked at the idle raw level during reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_sync1 <= POL;
        r_sync2 <= POL;
      end else begin
        r_sync1 <= raw_in[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce: any bounce back to the current level restarts the window.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_dcnt  <= '0;
        r_level <= 1'b0;
      end else if (w_s == r_level) begin
        r_dcnt  <= '0;
      end else if (w_tog) begin
        r_dcnt  <= '0;
        r_level <= ~r_level;
      end else begin
        r_dcnt  <= r_dcnt + 1'b1;
      end
    end

`ifdef KEY_COND_REPEAT_EN
    localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] r_rcnt;
    logic          r_rfirst;

    // Repeat only while the level is steady high; the release edge wins.
    assign w_rep = r_level && !w_tog && (r_rcnt == (r_rfirst ? RPER : RDLY));

    // Repeat timer: first interval is the delay, later ones the period.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_rcnt   <= '0;
        r_rfirst <= 1'b0;
      end else if (!r_level || w_tog) begin
        r_rcnt   <= '0;
        r_rfirst <= 1'b0;
      end else if (w_rep) begin
        r_rcnt   <= '0;
        r_rfirst <= 1'b1;
      end else begin
        r_rcnt   <= r_rcnt + 1'b1;
      end
    end
`else
    assign w_rep = 1'b0;
`endif

    // Strobes are registered alongside the level change they report.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_press <= (w_tog & ~r_level) | w_rep;
        r_rel   <= w_tog & r_level;
      end
    end

    assign level[gi]     = r_level;
    assign press[gi]     = r_press;
    assign release_o[gi] = r_rel;
  end

  typedef enum logic {S_HOLD = 1'b0, S_RUN = 1'b1} rst_state_t;
  rst_state_t    r_state, w_state_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;

  // Reset stretcher state: async entry to HOLD, synchronous exit to RUN.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_HOLD;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // Count POR_HOLD edges in HOLD, then release the reset and stay in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    rst_out_n   = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_hcnt == HMAX) begin
          w_state_nxt = S_RUN;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt  = r_hcnt + 1'b1;
        end
      end
      S_RUN:   rst_out_n = 1'b1;
      default: w_state_nxt = S_HOLD;
    endcase
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: CHANNELS=4, DEBOUNCE_CYCLES=4,
// POR_HOLD=8, ACTIVE_LOW=1; repeat scenario built with KEY_COND_REPEAT_EN.
module tb_key_conditioner;
  logic       clk;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] level, press, rel;
  logic       rst_out_n;
  int         n_pass = 0;
  int         n_tot  = 0;

  key_conditioner #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .POR_HOLD(8),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .raw_in(raw), .level(level),
    .press(press), .release_o(rel), .rst_out_n(rst_out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then park on the falling edge for drive/sample.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    n_tot++;
    if ({level, press, rel, rst_out_n} !== 13'd0)
      $display("FAIL reset_outputs got %b want 0", {level, press, rel, rst_out_n});
    else n_pass++;
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_tot++;
      if (rst_out_n !== (e >= 8))
        $display("FAIL reset_stretch edge %0d got %b want %b", e, rst_out_n, (e >= 8));
      else n_pass++;
      n_tot++;
      if ({level, press, rel} !== 12'd0)
        $display("FAIL reset_quiet edge %0d got %b want 0", e, {level, press, rel});
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    raw[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b0010 : 4'b0000))
        $display("FAIL press_level edge %0d got %b", e, level);
      else n_pass++;
      n_tot++;
      if (press !== ((e == 6) ? 4'b0010 : 4'b0000) || rel !== 4'b0000)
        $display("FAIL press_strobe edge %0d got press %b rel %b", e, press, rel);
      else n_pass++;
    end
    raw[1] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b0000 : 4'b0010))
        $display("FAIL release_level edge %0d got %b", e, level);
      else n_pass++;
      n_tot++;
      if (rel !== ((e == 6) ? 4'b0010 : 4'b0000) || press !== 4'b0000)
        $display("FAIL release_strobe edge %0d got rel %b press %b", e, rel, press);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        raw[2] = (c == 3);
        tick();
        n_tot++;
        if ({level, press, rel} !== 12'd0)
          $display("FAIL bounce_reject rep %0d cyc %0d got %b want 0", r, c, {level, press, rel});
        else n_pass++;
      end
    end
    raw[2] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b0100 : 4'b0000) || press !== ((e == 6) ? 4'b0100 : 4'b0000))
        $display("FAIL bounce_accept edge %0d got level %b press %b", e, level, press);
      else n_pass++;
    end
    raw[2] = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    n_tot++;
    if (level !== 4'b0000)
      $display("FAIL bounce_release got %b want 0000", level);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    raw[0] = 1'b0;
    raw[3] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b1001 : 4'b0000) || press !== ((e == 6) ? 4'b1001 : 4'b0000))
        $display("FAIL simul_press edge %0d got level %b press %b", e, level, press);
      else n_pass++;
    end
    raw[0] = 1'b1;
    raw[3] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b0000 : 4'b1001) || rel !== ((e == 6) ? 4'b1001 : 4'b0000))
        $display("FAIL simul_release edge %0d got level %b rel %b", e, level, rel);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    raw[1] = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    n_tot++;
    if (rst_out_n !== 1'b0 || level !== 4'b0000)
      $display("FAIL mid_state got rst_out_n %b level %b want 0 0000", rst_out_n, level);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({level, press, rel, rst_out_n} !== 13'd0)
      $display("FAIL mid_abort got %b want 0", {level, press, rel, rst_out_n});
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_tot++;
      if (level !== ((e >= 6) ? 4'b0010 : 4'b0000) || press !== ((e == 6) ? 4'b0010 : 4'b0000))
        $display("FAIL mid_restart edge %0d got level %b press %b", e, level, press);
      else n_pass++;
      n_tot++;
      if (rst_out_n !== (e >= 8))
        $display("FAIL mid_stretch edge %0d got %b want %b", e, rst_out_n, (e >= 8));
      else n_pass++;
    end
    raw[1] = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
  endtask

`ifdef KEY_COND_REPEAT_EN
  task automatic test_repeat();
    logic exp_p, exp_l, exp_r;
    raw[0] = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_p = (e == 6) || (e == 16) || (e == 19) || (e == 22);
      exp_l = (e >= 6) && (e < 25);
      exp_r = (e == 25);
      n_tot++;
      if (press[0] !== exp_p || level[0] !== exp_l || rel[0] !== exp_r)
        $display("FAIL repeat edge %0d got p%b l%b r%b want p%b l%b r%b",
                 e, press[0], level[0], rel[0], exp_p, exp_l, exp_r);
      else n_pass++;
      if (e == 19) raw[0] = 1'b1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
`ifdef KEY_COND_REPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
